alu_share_arbiter: RTL

- Shares one combinational 6-bit ALU (operands A, B; 2-bit Op; result R) between NREQ requesters.
- Round-robin grant, at most one operation per cycle, valid/ready handshakes on every request port and on the single response port.
- Registers the ALU result with the winner's ID and counts completed operations.
- Sits between client blocks and the ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_share_arbiter_pkg.sv | 10 +
 rtl/alu_share_arbiter_rr_arbiter.sv | 36 +++
 rtl/alu_share_arbiter.sv | 60 ++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared ALU opcode encoding and default width
package alu_share_arbiter_pkg;
  localparam int DEF_WIDTH = 6;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;
endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// alu_share_arbiter_rr_arbiter: round-robin grant starting at rr_ptr, pointer advances past each winner
module alu_share_arbiter_rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      pos;
  logic [2**IDW-1:0]   req_x;
  logic                hit;
  assign req_x = (2**IDW)'(req);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(rr_ptr) + k >= NREQ) ? IDW'(int'(rr_ptr) + k - NREQ) : IDW'(int'(rr_ptr) + k);
      if (!hit && req_x[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end
  assign gnt = (en && hit) ? NREQ'(1) << idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= '0;
    else if (en && hit) rr_ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU among NREQ requesters with registered result and completion count
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2,
  parameter int IDW   = 3,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_r,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_r,
  output logic [IDW-1:0]    resp_id,
  output logic [1:0]        resp_op,
  output logic [CNTW-1:0]   op_count
);
  logic           slot_free;
  logic           grant;
  logic [IDW-1:0] win;
  assign slot_free = !resp_valid || resp_ready;
  assign grant = |req_ready;
  alu_share_arbiter_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(slot_free),
    .gnt(req_ready),
    .idx(win)
  );
  assign alu_a  = grant ? WIDTH'(req_a >> (int'(win) * WIDTH)) : '0;
  assign alu_b  = grant ? WIDTH'(req_b >> (int'(win) * WIDTH)) : '0;
  assign alu_op = grant ? 2'(req_op >> (int'(win) * 2)) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_r     <= '0;
      resp_id    <= '0;
      resp_op    <= '0;
      op_count   <= '0;
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_r     <= alu_r;
      resp_id    <= win;
      resp_op    <= alu_op;
      op_count   <= op_count + 1'b1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
endmodule
